// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// One result bit per cycle: launch, DATA_WIDTH iterations, then sign fix and commit.
module mul_div_unit #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  CLK,
   input  logic                  rst,
   input  logic                  start,
   input  logic [1:0]            op,
   input  logic [DATA_WIDTH-1:0] srcA,
   input  logic [DATA_WIDTH-1:0] srcB,
   input  logic                  wr_hi,
   input  logic                  wr_lo,
   input  logic [DATA_WIDTH-1:0] wd,
   output logic                  busy,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] HI,
   output logic [DATA_WIDTH-1:0] LO
);

   localparam int W  = DATA_WIDTH;
   localparam int CW = (W > 1) ? $clog2(W) : 1;

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

   // Handshake: start is taken only while busy=0 (IDLE); done pulses for one
   // cycle when HI/LO hold the new result, and busy is already low then.
   state_t          state_q, state_d;
   logic [1:0]      op_q, op_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [W-1:0]    acc_hi_q, acc_hi_d;
   logic [W-1:0]    acc_lo_q, acc_lo_d;
   logic [W-1:0]    opb_q, opb_d;
   logic            neg_quo_q, neg_quo_d;
   logic            neg_rem_q, neg_rem_d;
   logic            div_zero_q, div_zero_d;
   logic [W-1:0]    hi_q, hi_d;
   logic [W-1:0]    lo_q, lo_d;
   logic            done_q, done_d;

   logic            is_signed;
   logic [W-1:0]    abs_a, abs_b;
   logic [W:0]      mul_sum;
   logic [W:0]      div_shift, div_diff;
   logic [2*W-1:0]  prod, prod_fix;
   logic [W-1:0]    quo_fix, rem_fix;

   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      cnt_d      = cnt_q;
      acc_hi_d   = acc_hi_q;
      acc_lo_d   = acc_lo_q;
      opb_d      = opb_q;
      neg_quo_d  = neg_quo_q;
      neg_rem_d  = neg_rem_q;
      div_zero_d = div_zero_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      done_d     = 1'b0;

      is_signed = ~op[0];
      abs_a     = (is_signed && srcA[W-1]) ? -srcA : srcA;
      abs_b     = (is_signed && srcB[W-1]) ? -srcB : srcB;

      // Multiply keeps {acc_hi, acc_lo} as partial product over the shifting multiplier.
      mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opb_q} : {(W+1){1'b0}});
      // Divide keeps remainder in acc_hi and shifts dividend/quotient through acc_lo.
      div_shift = {acc_hi_q, acc_lo_q[W-1]};
      div_diff  = div_shift - {1'b0, opb_q};

      prod      = {acc_hi_q, acc_lo_q};
      prod_fix  = neg_quo_q ? -prod : prod;
      quo_fix   = neg_quo_q ? -acc_lo_q : acc_lo_q;
      rem_fix   = neg_rem_q ? -acc_hi_q : acc_hi_q;

      unique case (state_q)
         S_IDLE: begin
            if (wr_hi) hi_d = wd;
            if (wr_lo) lo_d = wd;
            if (start) begin
               op_d       = op;
               acc_hi_d   = '0;
               acc_lo_d   = abs_a;
               opb_d      = abs_b;
               neg_quo_d  = is_signed & (srcA[W-1] ^ srcB[W-1]);
               neg_rem_d  = is_signed & srcA[W-1];
               div_zero_d = (srcB == '0);
               cnt_d      = '0;
               state_d    = S_CALC;
            end
         end
         S_CALC: begin
            if (op_q[1]) begin
               if (!div_diff[W]) begin
                  acc_hi_d = div_diff[W-1:0];
                  acc_lo_d = {acc_lo_q[W-2:0], 1'b1};
               end else begin
                  acc_hi_d = div_shift[W-1:0];
                  acc_lo_d = {acc_lo_q[W-2:0], 1'b0};
               end
            end else begin
               acc_hi_d = mul_sum[W:1];
               acc_lo_d = {mul_sum[0], acc_lo_q[W-1:1]};
            end
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(W-1)) state_d = S_FIX;
         end
         S_FIX: begin
            if (!op_q[1]) begin
               hi_d = prod_fix[2*W-1:W];
               lo_d = prod_fix[W-1:0];
            end else if (!div_zero_q) begin
               hi_d = rem_fix;
               lo_d = quo_fix;
            end
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (rst) begin
         state_q    <= S_IDLE;
         op_q       <= '0;
         cnt_q      <= '0;
         acc_hi_q   <= '0;
         acc_lo_q   <= '0;
         opb_q      <= '0;
         neg_quo_q  <= 1'b0;
         neg_rem_q  <= 1'b0;
         div_zero_q <= 1'b0;
         hi_q       <= '0;
         lo_q       <= '0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         cnt_q      <= cnt_d;
         acc_hi_q   <= acc_hi_d;
         acc_lo_q   <= acc_lo_d;
         opb_q      <= opb_d;
         neg_quo_q  <= neg_quo_d;
         neg_rem_q  <= neg_rem_d;
         div_zero_q <= div_zero_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
         done_q     <= done_d;
      end
   end

   assign busy = (state_q != S_IDLE);
   assign done = done_q;
   assign HI   = hi_q;
   assign LO   = lo_q;

endmodule
